// File: rtl/gate_sweep_ctrl_if.sv
// Handshake and result bundle between the lab harness and the gate sweep controller.
// The harness side (master) drives start/abort and the gate output; the controller is the slave.
interface gate_sweep_ctrl_if #(
  parameter int unsigned N_IN = 2
) ();
  logic            start;
  logic            abort;
  logic            op;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_fail_vec;
  logic            first_fail_valid;

  modport master (
    output start, abort, op,
    input  vec, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );

  modport slave (
    input  start, abort, op,
    output vec, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive truth-table sweeper: walks every input vector of a small combinational gate,
// holds each for a settle time, samples the gate output and accumulates mismatch results.
module gate_sweep_ctrl #(
  parameter int unsigned        N_IN   = 2,
  parameter int unsigned        SETTLE = 2,
  parameter logic [2**N_IN-1:0] EXPECT = 4'b1001
) (
  input logic              clk,
  input logic              rst_n,
  gate_sweep_ctrl_if.slave sweep_if
);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  localparam logic [3:0]      SettleLoad = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] VecLast    = {N_IN{1'b1}};
  localparam logic [N_IN:0]   ErrMax     = {1'b1, {N_IN{1'b0}}};

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ffv_q, ffv_d;
  logic            ffvalid_q, ffvalid_d;
  logic            pass_q, pass_d;

  logic            busy;
  logic            mismatch;
  logic [N_IN:0]   err_inc;

  assign busy     = (state_q == StSettle) || (state_q == StCheck);
  assign mismatch = sweep_if.op != EXPECT[vec_q];
  assign err_inc  = (err_q == ErrMax) ? err_q : err_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    pass_d    = pass_q;

    // Abort only matters mid-sweep; partial results are deliberately kept for inspection.
    if (busy && sweep_if.abort) begin
      state_d = StIdle;
      vec_d   = '0;
      cnt_d   = '0;
      pass_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (sweep_if.start) begin
            state_d   = StSettle;
            vec_d     = '0;
            cnt_d     = SettleLoad;
            err_d     = '0;
            ffv_d     = '0;
            ffvalid_d = 1'b0;
            pass_d    = 1'b0;
          end
        end
        StSettle: begin
          if (cnt_q == 4'd0) begin
            state_d = StCheck;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        StCheck: begin
          if (mismatch) begin
            err_d = err_inc;
            if (!ffvalid_q) begin
              ffv_d     = vec_q;
              ffvalid_d = 1'b1;
            end
          end
          if (vec_q == VecLast) begin
            state_d = StDone;
            pass_d  = (err_d == '0);
          end else begin
            state_d = StSettle;
            vec_d   = vec_q + 1'b1;
            cnt_d   = SettleLoad;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      vec_q     <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      pass_q    <= pass_d;
    end
  end

  assign sweep_if.vec              = vec_q;
  assign sweep_if.busy             = busy;
  assign sweep_if.done             = (state_q == StDone);
  assign sweep_if.pass             = pass_q;
  assign sweep_if.err_count        = err_q;
  assign sweep_if.first_fail_vec   = ffv_q;
  assign sweep_if.first_fail_valid = ffvalid_q;

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
- Exhaustive truth-table sequencer/checker for a small combinational gate (XNOR, AND, OR, ... from the Week-1 gate set).
- Drives the gate's inputs through every input vector and waits a programmable settle time at each vector.
- Samples the gate output, compares it against an expected truth table, and reports pass/fail, the mismatch count and the first failing vector.
- Sits between a top-level lab harness and one gate instance; the gate stays purely combinational.

Parameters:
- N_IN, 2, number of gate inputs; vectors run 0 .. 2^N_IN-1.
- SETTLE, 2, cycles each vector is held before sampling; legal range 1..15.
- EXPECT, 4'b1001, expected output per vector; bit k = expected op for vector k. The default is XNOR.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled in IDLE or DONE only.
- abort  input  1  cancel a running sweep.
- vec  output  N_IN  drive to gate inputs; bit0 = input1, bit1 = input2, ...
- op  input  1  gate output under test.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; level, held until next start.
- pass  output  1  valid while done; 1 when err_count == 0.
- err_count  output  N_IN+1  number of mismatching vectors; saturates at 2^N_IN.
- first_fail_vec  output  N_IN  lowest vector that mismatched.
- first_fail_valid  output  1  at least one mismatch recorded this sweep.

Behaviour:
- One clock domain; reset is asynchronous and active-low (clk, rst_n). The polarity and synchronicity are fixed.
- Reset values:
  - state = IDLE; vec = 0; settle counter = 0.
  - busy = 0; done = 0; pass = 0.
  - err_count = 0; first_fail_vec = 0; first_fail_valid = 0.
- States are IDLE, SETTLE, CHECK and DONE.
- IDLE/DONE with start = 1 at an edge:
  - next state = SETTLE; vec = 0; settle counter = SETTLE-1.
  - err_count, first_fail_* and done are cleared.
  - busy = 1 from that edge on.
- SETTLE:
  - vec held stable; the counter decrements each cycle.
  - Counter == 0 at an edge -> CHECK.
  - Each vector is therefore presented for exactly SETTLE cycles before CHECK.
- CHECK (one cycle). At its closing edge, compare op with EXPECT[vec]. On mismatch:
  - err_count increments, saturating.
  - If first_fail_valid == 0: first_fail_vec = vec and first_fail_valid = 1.
- Leaving CHECK:
  - If vec == 2^N_IN-1 -> DONE, with busy = 0, done = 1, pass = (final err_count == 0).
  - Otherwise vec = vec+1 with wrap disabled, counter reloads to SETTLE-1, -> SETTLE.
- Latency: start edge to done = 1 is exactly 2^N_IN*(SETTLE+1) cycles. The default is 12.
- DONE:
  - Results and vec hold their values.
  - start re-runs the sweep, with results cleared on the same edge.
- start while busy: ignored. No restart, no queueing.
- abort at an edge while busy -> IDLE:
  - vec = 0; busy = 0; done = 0; pass = 0.
  - err_count and first_fail_* keep their partial values.
- abort and start at the same edge: abort wins if busy; start wins in IDLE/DONE.
- abort in IDLE/DONE: no effect.
- rst_n low at any time, including mid-sweep: immediate return to the reset values, independent of clk.
- op is sampled only at the CHECK edge; glitches during SETTLE are ignored.

Test Plan:
- Correct XNOR model, defaults, pulse start -> done rises after 12 cycles; pass = 1, err_count = 0, first_fail_valid = 0. vec sequence is 0,1,2,3, each held 3 cycles.
- Op stuck at 0 -> done after 12 cycles; err_count = 2 (vectors 0 and 3), first_fail_vec = 0, pass = 0.
- XOR model (inverted XNOR) -> err_count = 4, first_fail_vec = 0, pass = 0. Then pulse start with the XNOR model -> results cleared on the start edge; pass = 1 after 12 more cycles.
- start re-pulsed at cycle 5 of a sweep -> ignored; done still at cycle 12. abort at cycle 7 -> busy = 0, done = 0, vec = 0 on the next edge. abort together with start in IDLE -> sweep starts.
- rst_n pulled low mid-SETTLE at vector 2 (async, between edges) -> all outputs at reset values immediately. After release, start gives a full 12-cycle sweep.
- N_IN = 3, SETTLE = 1, EXPECT = 8'h80 (3-input AND), correct model -> done after 16 cycles, pass = 1. Op stuck at 1 -> err_count = 7, first_fail_vec = 0.
